// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive sequencer.
// The line is sampled on the shared oversample strobe. A start bit is qualified
// at its middle, and data bits are sampled at mid-bit, LSB first. The stop bit
// is then checked. Completed words go to the host over a valid/ready
// handshake. Framing errors are reported as a pulse; dropped words set a
// sticky overrun flag.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge
// START | counting to mid start bit to reject glitches
// DATA  | sampling DATA_BITS data bits at mid-bit
// STOP  | counting to mid stop bit, then deliver or flag framing error
// BRK   | stop bit was 0; wait for line to return high before re-arming
module uart_rx_ctrl #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 samp_clk,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 ovr_clr,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BRK
    } state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 deliver;
    logic                 fe_set;
    logic                 drop;

    // Next-state, counter and shift-register logic; only moves on oversample ticks.
    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        deliver   = 1'b0;
        fe_set    = 1'b0;
        if (samp_clk) begin
            case (state)
                S_IDLE: begin
                    if (!rx_in) begin
                        state_nxt = S_START;
                        tick_nxt  = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_nxt = '0;
                        if (!rx_in) begin
                            state_nxt = S_DATA;
                            bit_nxt   = '0;
                        end else begin
                            // glitch shorter than half a bit: silently re-arm
                            state_nxt = S_IDLE;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_ONE;
                    end
                end
                S_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt  = '0;
                        shreg_nxt = {rx_in, shreg[DATA_BITS-1:1]};
                        bit_nxt   = bit_cnt + BIT_ONE;
                        if (bit_cnt == BIT_LAST) begin
                            state_nxt = S_STOP;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_ONE;
                    end
                end
                S_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_nxt = '0;
                        if (rx_in) begin
                            deliver   = 1'b1;
                            state_nxt = S_IDLE;
                        end else begin
                            fe_set    = 1'b1;
                            state_nxt = S_BRK;
                        end
                    end else begin
                        tick_nxt = tick_cnt + TICK_ONE;
                    end
                end
                S_BRK: begin
                    // a held-low line (break) must not look like a new start bit
                    if (rx_in) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    tick_nxt  = '0;
                    bit_nxt   = '0;
                end
            endcase
        end
    end

    // A finished word is dropped only if the previous one is still pending and not taken this clk.
    assign drop = deliver && valid && !ready;

    assign busy = (state != S_IDLE);

    // FSM state, counters and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            tick_cnt <= tick_nxt;
            bit_cnt  <= bit_nxt;
            shreg    <= shreg_nxt;
        end
    end

    // Host-side output word, handshake, error pulse and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= fe_set;
            if (deliver && (!valid || ready)) begin
                data  <= shreg;
                valid <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            // a drop in the same clk as a clear keeps the flag set
            if (drop) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a table of frames plus hand-written handshake,
// overrun and reset sequences. Expected words go into a scoreboard queue when
// a frame is driven. They are popped whenever the bench sees valid & ready.
module tb_uart_rx_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          samp_clk = 1'b0;
    logic          rx_in = 1'b1;
    logic          ready = 1'b1;
    logic          ovr_clr = 1'b0;
    logic [DB-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          overrun;
    logic          busy;

    uart_rx_ctrl #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .reset     (reset),
        .samp_clk  (samp_clk),
        .rx_in     (rx_in),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            fe_cnt = 0;
    int            acc_cnt = 0;
    logic [DB-1:0] sb[$];

    typedef struct {
        logic [DB-1:0] d;
        logic          stop;
        int            exp_fe;
        int            exp_acc;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // oversample strobe: one clk high every 4 clks
    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            c++;
            samp_clk = (c % 4 == 0);
        end
    end

    // monitor: frame_err pulse count and scoreboard pops on accepted words
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (frame_err === 1'b1) fe_cnt++;
            if (valid === 1'b1 && ready === 1'b1) begin
                acc_cnt++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_unexpected: got word %0h, expected no word", data);
                end else begin
                    chk("sb_data", 32'(data), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "timeout");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!samp_clk) @(posedge clk);
        end
    endtask

    task automatic set_rx(input logic b);
        @(negedge clk);
        rx_in = b;
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    // sel: 0 none, 1 pulse ovr_clr, 2 pulse ready -- in the clk of the stop-bit sample
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input int sel);
        set_rx(1'b0);
        wait_ticks(OS);
        for (int i = 0; i < DB; i++) begin
            set_rx(d[i]);
            wait_ticks(OS);
        end
        set_rx(stop);
        wait_ticks(OS / 2);
        if (sel != 0) begin
            repeat (4) @(negedge clk);
            if (sel == 1) ovr_clr = 1'b1;
            else          ready   = 1'b1;
            @(negedge clk);
            ovr_clr = 1'b0;
            if (sel == 2) ready = 1'b0;
            wait_ticks(OS / 2 - 1);
        end else begin
            wait_ticks(OS / 2);
        end
    endtask

    initial begin
        int fe0;
        int a0;

        vt[0] = '{8'hA5, 1'b1, 0, 1};
        vt[1] = '{8'h5A, 1'b1, 0, 1};
        vt[2] = '{8'h00, 1'b1, 0, 1};
        vt[3] = '{8'hFF, 1'b1, 0, 1};
        vt[4] = '{8'h55, 1'b0, 1, 0};
        vt[5] = '{8'h0F, 1'b1, 0, 1};
        vt[6] = '{8'h81, 1'b1, 0, 1};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        settle();
        chk("rst_data", 32'(data), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_busy", 32'(busy), 0);
        wait_ticks(4);

        // table-driven frames, including a framing error followed by a break
        for (int i = 0; i < 7; i++) begin
            fe0 = fe_cnt;
            a0  = acc_cnt;
            if (vt[i].stop) sb.push_back(vt[i].d);
            send_frame(vt[i].d, vt[i].stop, 0);
            if (!vt[i].stop) begin
                wait_ticks(20);
                settle();
                chk("brk_busy", 32'(busy), 1);
                chk("brk_fe_once", 32'(fe_cnt - fe0), 1);
                set_rx(1'b1);
            end
            wait_ticks(3);
            settle();
            chk("vec_fe", 32'(fe_cnt - fe0), 32'(vt[i].exp_fe));
            chk("vec_acc", 32'(acc_cnt - a0), 32'(vt[i].exp_acc));
            chk("vec_busy", 32'(busy), 0);
            chk("vec_valid", 32'(valid), 0);
        end

        // false start: low for 5 ticks, back to idle exactly at tick 8
        fe0 = fe_cnt;
        a0  = acc_cnt;
        set_rx(1'b0);
        wait_ticks(3);
        settle();
        chk("fs_busy", 32'(busy), 1);
        wait_ticks(2);
        set_rx(1'b1);
        wait_ticks(3);
        settle();
        chk("fs_busy_t7", 32'(busy), 1);
        wait_ticks(1);
        settle();
        chk("fs_idle_t8", 32'(busy), 0);
        chk("fs_fe", 32'(fe_cnt - fe0), 0);
        chk("fs_acc", 32'(acc_cnt - a0), 0);
        wait_ticks(4);
        sb.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 0);
        wait_ticks(3);
        chk("fs_next_acc", 32'(acc_cnt - a0), 1);

        // overrun: second word dropped while first is pending
        @(negedge clk);
        ready = 1'b0;
        a0 = acc_cnt;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, 0);
        wait_ticks(2);
        send_frame(8'h22, 1'b1, 0);
        wait_ticks(2);
        settle();
        chk("ovr_valid", 32'(valid), 1);
        chk("ovr_data", 32'(data), 32'h11);
        chk("ovr_set", 32'(overrun), 1);
        @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        settle();
        chk("ovr_valid_drop", 32'(valid), 0);
        chk("ovr_acc", 32'(acc_cnt - a0), 1);
        chk("ovr_sticky", 32'(overrun), 1);
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        settle();
        chk("ovr_clr", 32'(overrun), 0);

        // clear coincident with a drop: set wins
        sb.push_back(8'h33);
        send_frame(8'h33, 1'b1, 0);
        wait_ticks(2);
        send_frame(8'h44, 1'b1, 1);
        settle();
        chk("ovr_clr_vs_set", 32'(overrun), 1);
        chk("ovr_hold_data", 32'(data), 32'h33);
        @(negedge clk);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        settle();
        chk("ovr_clr2", 32'(overrun), 0);

        // ready in the same clk a new word completes: old taken, new loaded, no overrun
        a0 = acc_cnt;
        sb.push_back(8'h66);
        send_frame(8'h66, 1'b1, 2);
        settle();
        chk("rdy_same_valid", 32'(valid), 1);
        chk("rdy_same_data", 32'(data), 32'h66);
        chk("rdy_same_ovr", 32'(overrun), 0);
        chk("rdy_same_acc", 32'(acc_cnt - a0), 1);
        @(negedge clk);
        ready = 1'b1;
        repeat (3) @(negedge clk);
        settle();
        chk("rdy_drain_valid", 32'(valid), 0);

        // reset mid-frame with a pending word and overrun set
        ready = 1'b0;
        send_frame(8'h77, 1'b1, 0);
        wait_ticks(2);
        send_frame(8'h78, 1'b1, 0);
        wait_ticks(2);
        set_rx(1'b0);
        wait_ticks(OS);
        for (int i = 0; i < 3; i++) begin
            set_rx(1'b1);
            wait_ticks(OS);
        end
        @(negedge clk);
        reset = 1'b1;
        rx_in = 1'b1;
        #1;
        chk("mid_rst_data", 32'(data), 0);
        chk("mid_rst_valid", 32'(valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ovr", 32'(overrun), 0);
        chk("mid_rst_fe", 32'(frame_err), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ready = 1'b1;
        a0 = acc_cnt;
        wait_ticks(40);
        settle();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_acc", 32'(acc_cnt - a0), 0);
        sb.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, 0);
        wait_ticks(3);
        settle();
        chk("post_rst_ff_acc", 32'(acc_cnt - a0), 1);
        chk("post_rst_ff_data", 32'(data), 32'hFF);

        chk("sb_empty", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
